// File: rtl/score_pkg.sv
// Shared definitions for the score display path: FSM states, score width,
// default ceiling and the 7-segment digit patterns used by the decoder.
package score_pkg;

    localparam int unsigned SCORE_W           = 7;
    localparam int unsigned MAX_SCORE_DEFAULT = 99;

    typedef enum logic [1:0] {
        ST_PLAY       = 2'd0,
        ST_OVER_SCORE = 2'd1,
        ST_OVER_HIGH  = 2'd2
    } state_e;

    // Segment pattern {g,f,e,d,c,b,a}, active-high; non-digits render blank.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Half-period timer: counts PERIOD clocks, toggles a phase bit at the end of
// each half-period and flags the last count of the period.
//   clk_i      clock
//   rst_i      asynchronous reset, active-high
//   restart_i  synchronous restart: counter and phase return to 0
//   phase_o    registered toggling phase bit (starts at 0)
//   done_c_o   combinational strobe, high in the last cycle of a period
module blink_timer #(
    parameter int unsigned PERIOD = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic phase_o,
    output logic done_c_o
);

    localparam int unsigned CNT_W = $clog2(PERIOD + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    assign done_c_o = (cnt_q == CNT_W'(PERIOD - 1));
    assign phase_o  = phase_q;

    // Next count / phase
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (restart_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (done_c_o) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/score_sequencer.sv
// Score controller for the two-digit display: running score, session high
// score and the play / game-over alternation between score and high score.
//   i_Clk, i_Rst    clock, asynchronous active-high reset
//   i_Add_Pulse     strobe: add i_Add_Amount (saturating at MAX_SCORE)
//   i_Add_Amount    points to add
//   i_Game_Over     strobe: round ended
//   i_Clear         strobe: start a new round (high score kept)
//   o_Score         value for the decoder (score or high score)
//   o_Blank         1 = blank both digits
//   o_High_Score    session high score
//   o_New_Record    last game-over set a new high score
module score_sequencer
    import score_pkg::*;
#(
    parameter int unsigned MAX_SCORE    = MAX_SCORE_DEFAULT,
    parameter int unsigned BLINK_CYCLES = 6_250_000,
    parameter int unsigned PHASE_CYCLES = 25_000_000
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Add_Pulse,
    input  logic [3:0]         i_Add_Amount,
    input  logic               i_Game_Over,
    input  logic               i_Clear,
    output logic [SCORE_W-1:0] o_Score,
    output logic               o_Blank,
    output logic [SCORE_W-1:0] o_High_Score,
    output logic               o_New_Record
);

    localparam logic [7:0] MAX8 = 8'(MAX_SCORE);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic [SCORE_W-1:0] disp_q, disp_d;
    logic               rec_q, rec_d;
    logic [7:0]         sum;
    logic [SCORE_W-1:0] sat;
    logic [SCORE_W-1:0] fin_score;
    logic               phase_done;
    logic               blink_phase;
    logic               blink_done_unused;
    logic               phase_bit_unused;

    // State register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) state_q <= ST_PLAY;
        else       state_q <= state_d;
    end

    // Next state; clear wins over everything
    always_comb begin
        state_d = state_q;
        if (i_Clear) begin
            state_d = ST_PLAY;
        end else begin
            case (state_q)
                ST_PLAY:       if (i_Game_Over) state_d = ST_OVER_SCORE;
                ST_OVER_SCORE: if (phase_done)  state_d = ST_OVER_HIGH;
                ST_OVER_HIGH:  if (phase_done)  state_d = ST_OVER_SCORE;
                default:       state_d = ST_PLAY;
            endcase
        end
    end

    // Score/high update and display selection; the sum is 8 bits so it never wraps
    always_comb begin
        sum       = 8'(score_q) + 8'(i_Add_Amount);
        sat       = (sum > MAX8) ? SCORE_W'(MAX8) : SCORE_W'(sum);
        score_d   = score_q;
        high_d    = high_q;
        rec_d     = rec_q;
        fin_score = score_q;
        if (i_Clear) begin
            score_d = '0;
            rec_d   = 1'b0;
        end else if (state_q == ST_PLAY) begin
            if (i_Add_Pulse) score_d = sat;
            if (i_Game_Over) begin
                // Points arriving with the game-over strobe still count
                fin_score = score_d;
                if (fin_score > high_q) begin
                    high_d = fin_score;
                    rec_d  = 1'b1;
                end else begin
                    rec_d  = 1'b0;
                end
            end
        end
        disp_d = (state_d == ST_OVER_HIGH) ? high_d : score_d;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            score_q <= '0;
            high_q  <= '0;
            rec_q   <= 1'b0;
            disp_q  <= '0;
        end else begin
            score_q <= score_d;
            high_q  <= high_d;
            rec_q   <= rec_d;
            disp_q  <= disp_d;
        end
    end

    // Blink only runs in OVER_SCORE; held at phase 0 (visible) elsewhere
    blink_timer #(.PERIOD(BLINK_CYCLES)) u_blink (
        .clk_i     (i_Clk),
        .rst_i     (i_Rst),
        .restart_i ((state_d != ST_OVER_SCORE) || (state_d != state_q)),
        .phase_o   (blink_phase),
        .done_c_o  (blink_done_unused)
    );

    // Phase timer paces the score/high alternation
    blink_timer #(.PERIOD(PHASE_CYCLES)) u_phase (
        .clk_i     (i_Clk),
        .rst_i     (i_Rst),
        .restart_i ((state_d == ST_PLAY) || (state_d != state_q)),
        .phase_o   (phase_bit_unused),
        .done_c_o  (phase_done)
    );

    assign o_Score      = disp_q;
    assign o_Blank      = blink_phase;
    assign o_High_Score = high_q;
    assign o_New_Record = rec_q;

endmodule
